// File: rtl/lsu_mem_master_if.sv
// Load/store request, response and data-memory port bundle for lsu_mem_master.
// The master modport is the LSU's view. The slave modport is the core plus memory side.
interface lsu_mem_master_if #(
  parameter int unsigned AW = 32
) ();
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32 load/store initiator for a word-addressed 1-cycle synchronous data memory.
// Sub-word stores are done as read-modify-write of the containing word.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned LH/LHU/SH/LW/SW with resp_err.
module lsu_mem_master #(
  parameter int unsigned AW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  lsu_mem_master_if.master  bus
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StResp} state_e;

  state_e        state_q;
  logic          ready_q, resp_valid_q, resp_err_q, mem_we_q;
  logic [31:0]   resp_rdata_q, mem_wdata_q;
  logic [AW-1:0] mem_addr_q;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [15:0]   wdata_q;

  logic        req_ok, misalign;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val, merged;

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  // Decode legality of the request currently offered at the input.
  always_comb begin
`ifdef MISALIGN_TRAP_EN
    misalign = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
               ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    if (bus.req_we) begin
      req_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
               (bus.req_funct3 == 3'b010);
    end else begin
      req_ok = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
               (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
               (bus.req_funct3 == 3'b101);
    end
    req_ok = req_ok && !misalign;
  end

  // Lane extraction for loads and lane merge for sub-word stores, from the word read in CAP.
  always_comb begin
    case (off_q)
      2'd0:    lane_byte = bus.mem_rdata[7:0];
      2'd1:    lane_byte = bus.mem_rdata[15:8];
      2'd2:    lane_byte = bus.mem_rdata[23:16];
      default: lane_byte = bus.mem_rdata[31:24];
    endcase
    lane_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    case (f3_q)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b010:  load_val = bus.mem_rdata;
      3'b100:  load_val = {24'h0, lane_byte};
      3'b101:  load_val = {16'h0, lane_half};
      default: load_val = 32'h0;
    endcase

    merged = bus.mem_rdata;
    if (f3_q[0]) begin
      if (off_q[1]) merged[31:16] = wdata_q;
      else          merged[15:0]  = wdata_q;
    end else begin
      case (off_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Request sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      wdata_q      <= 16'h0;
    end else begin
      resp_valid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            ready_q <= 1'b0;
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            off_q   <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata[15:0];
            if (!req_ok) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              resp_err_q <= 1'b0;
              mem_addr_q <= {2'b00, bus.req_addr[AW-1:2]};
              if (bus.req_we && (bus.req_funct3 == 3'b010)) begin
                // Full-word store needs no read.
                state_q     <= StWr;
                mem_we_q    <= 1'b1;
                mem_wdata_q <= bus.req_wdata;
              end else begin
                state_q <= StRd;
              end
            end
          end
        end
        StRd: state_q <= StCap;
        StCap: begin
          if (we_q) begin
            state_q     <= StWr;
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merged;
          end else begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_val;
          end
        end
        StWr: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0;
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master against a 1-cycle synchronous RAM model.
module tb_lsu_mem_master;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          we_k;   // cycle after accept with mem_we=1, 0 = never
    int          widx;   // memory word to inspect afterwards, -1 = none
    logic [31:0] wval;
    int          maddr;  // expected mem_addr at response, -1 = don't check
  } vec_t;

  logic clk;
  logic rst_n;
  logic preload;
  logic [31:0] mem [1024];
  int   n_tests;
  int   n_fail;
  vec_t vecs[$];

  lsu_mem_master_if #(.AW(32)) bus ();

  lsu_mem_master #(.AW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data refreshes only on non-write cycles.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[5]  <= 32'h8899AABB;
      mem[10] <= 32'h01020304;
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
    end else begin
      bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                     input logic err, input int we_k, input int widx, input logic [31:0] wval,
                     input int maddr);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.lat = lat; v.rdata = rdata;
    v.err = err; v.we_k = we_k; v.widx = widx; v.wval = wval; v.maddr = maddr;
    vecs.push_back(v);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   k, we_k, we_cnt;
    logic done, rdy1;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    // Junk on the request fields must be ignored once accepted.
    bus.req_valid  = 1'b0;
    bus.req_we     = ~v.we;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    k = 1; we_k = 0; we_cnt = 0; done = 1'b0; rdy1 = bus.req_ready;
    while (!done && k <= 10) begin
      if (bus.mem_we) begin
        we_cnt++;
        if (we_k == 0) we_k = k;
      end
      if (bus.resp_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    check($sformatf("v%0d_done", idx), {31'h0, done}, 32'h1);
    if (done) begin
      check($sformatf("v%0d_busy_ready", idx), {31'h0, rdy1}, 32'h0);
      check($sformatf("v%0d_lat", idx), k, v.lat);
      check($sformatf("v%0d_rdata", idx), bus.resp_rdata, v.rdata);
      check($sformatf("v%0d_err", idx), {31'h0, bus.resp_err}, {31'h0, v.err});
      check($sformatf("v%0d_we_cycle", idx), we_k, v.we_k);
      check($sformatf("v%0d_we_count", idx), we_cnt, (v.we_k != 0) ? 1 : 0);
      if (v.maddr >= 0) check($sformatf("v%0d_maddr", idx), bus.mem_addr, v.maddr);
      if (v.widx >= 0) check($sformatf("v%0d_word", idx), mem[v.widx], v.wval);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_pulse", idx), {31'h0, bus.resp_valid}, 32'h0);
      check($sformatf("v%0d_idle_ready", idx), {31'h0, bus.req_ready}, 32'h1);
    end
  endtask

  initial begin
    vec_t v;
    int   k;
    logic seen;
    n_tests = 0;
    n_fail  = 0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst_n   = 1'b0;
    preload = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    preload = 1'b0;
    check("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_rdata", bus.resp_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    //  we    f3      addr   wdata         lat rdata         err wek widx wval          maddr
    add(1'b0, 3'b010, 32'h14, 32'h0,        3, 32'h8899AABB, 0, 0, -1, 32'h0,        5);
    add(1'b0, 3'b000, 32'h17, 32'h0,        3, 32'hFFFFFF88, 0, 0, -1, 32'h0,        5);
    add(1'b0, 3'b100, 32'h17, 32'h0,        3, 32'h00000088, 0, 0, -1, 32'h0,        5);
    add(1'b0, 3'b001, 32'h16, 32'h0,        3, 32'hFFFF8899, 0, 0, -1, 32'h0,        5);
    add(1'b0, 3'b101, 32'h14, 32'h0,        3, 32'h0000AABB, 0, 0, -1, 32'h0,        5);
    add(1'b0, 3'b000, 32'h14, 32'h0,        3, 32'hFFFFFFBB, 0, 0, -1, 32'h0,        5);
    add(1'b0, 3'b100, 32'h15, 32'h0,        3, 32'h000000AA, 0, 0, -1, 32'h0,        5);
`ifdef MISALIGN_TRAP_EN
    add(1'b0, 3'b010, 32'h15, 32'h0,        1, 32'h0,        1, 0, -1, 32'h0,       -1);
    add(1'b0, 3'b001, 32'h15, 32'h0,        1, 32'h0,        1, 0, -1, 32'h0,       -1);
`else
    add(1'b0, 3'b010, 32'h15, 32'h0,        3, 32'h8899AABB, 0, 0, -1, 32'h0,        5);
    add(1'b0, 3'b001, 32'h15, 32'h0,        3, 32'hFFFFAABB, 0, 0, -1, 32'h0,        5);
`endif
    add(1'b0, 3'b011, 32'h14, 32'h0,        1, 32'h0,        1, 0,  5, 32'h8899AABB, -1);
    add(1'b1, 3'b100, 32'h14, 32'hFFFFFFFF, 1, 32'h0,        1, 0,  5, 32'h8899AABB, -1);
    add(1'b1, 3'b000, 32'h15, 32'h12345677, 4, 32'h0,        0, 3,  5, 32'h889977BB,  5);
    add(1'b1, 3'b001, 32'h16, 32'h0000CAFE, 4, 32'h0,        0, 3,  5, 32'hCAFE77BB,  5);
    add(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 2, 32'h0,        0, 1,  8, 32'hDEADBEEF,  8);
    add(1'b0, 3'b010, 32'h20, 32'h0,        3, 32'hDEADBEEF, 0, 0, -1, 32'h0,        8);
    add(1'b1, 3'b000, 32'h24, 32'h000000A5, 4, 32'h0,        0, 3,  9, 32'h000000A5,  9);
    add(1'b1, 3'b000, 32'h27, 32'hFFFFFF11, 4, 32'h0,        0, 3,  9, 32'h110000A5,  9);
    add(1'b0, 3'b000, 32'h24, 32'h0,        3, 32'hFFFFFFA5, 0, 0, -1, 32'h0,        9);
    add(1'b0, 3'b101, 32'h26, 32'h0,        3, 32'h00001100, 0, 0, -1, 32'h0,        9);
    add(1'b0, 3'b001, 32'h26, 32'h0,        3, 32'h00001100, 0, 0, -1, 32'h0,        9);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset asserted while an SB is in its write cycle.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h28;
    bus.req_wdata  = 32'h00000055;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    k = 1;
    while (!bus.mem_we && k <= 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("rstwr_reach_wr", k, 3);
    rst_n = 1'b0;
    #1;
    check("rstwr_we_low", {31'h0, bus.mem_we}, 32'h0);
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      seen = seen | bus.resp_valid;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      seen = seen | bus.resp_valid;
    end
    check("rstwr_no_resp", {31'h0, seen}, 32'h0);
    check("rstwr_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rstwr_word", mem[10], 32'h01020304);

    v.we = 1'b0; v.f3 = 3'b010; v.addr = 32'h28; v.wdata = 32'h0; v.lat = 3;
    v.rdata = 32'h01020304; v.err = 1'b0; v.we_k = 0; v.widx = -1; v.wval = 32'h0;
    v.maddr = 10;
    run_vec(100, v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
